bcd_share_arbiter: RTL and testbench
====================================

# bcd_share_arbiter

Round-robin arbiter and sequencer that shares one combinational BCD converter among `NUM_REQ` display clients (score, speed, timer fields, and so on). Each client submits an 8-bit binary value with a request/acknowledge handshake. The block forwards the winning value to the shared converter, registers the resulting tens and ones digits, and returns them tagged with the client index. It sits between the game-state logic and the hex/seven-segment display drivers.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index; must equal `$clog2(NUM_REQ)`.

Ports:
- `clock`  in  1: single system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  `NUM_REQ`: per-client request level.
- `number_flat`  in  `8*NUM_REQ`: client i's value on bits `[8*i+7:8*i]`; held stable while `req[i]` is high.
- `grant`  out  `NUM_REQ`: one-hot, high for the client being served, from arbitration until ack.
- `ack`  out  `NUM_REQ`: one-hot, one-cycle pulse; results are valid in that cycle.
- `busy`  out  1: high in every state except IDLE.
- `result_id`  out  `ID_W`: index of the client that was served.
- `result_tens`  out  4: registered tens digit.
- `result_ones`  out  4: registered ones digit.
- `result_ovf`  out  1: high if the served value exceeded 99.
- `conv_number`  out  8: registered operand driven to the shared converter.
- `conv_tens`  in  4: converter tens output (combinational from `conv_number`).
- `conv_ones`  in  4: converter ones output (combinational from `conv_number`).

## Operation
- State machine: IDLE -> CONV -> ACK -> IDLE.
- IDLE:
  - If `req != 0`, select the winner round-robin, starting the search at `rr_ptr` and wrapping from `NUM_REQ-1` to 0.
  - At the edge: register `sel_id`, set `grant[sel_id]`, load `conv_number` from the winner's value, set the overflow flag to `(value > 99)`, go to CONV.
  - If `req == 0`, stay in IDLE.
- CONV: `conv_number` is stable. At the edge, register `conv_tens` and `conv_ones` into `result_tens` and `result_ones`, and copy `result_ovf`. Go to ACK.
- ACK:
  - `ack[sel_id]=1`, `result_id=sel_id`.
  - At the edge: clear `grant`, set `rr_ptr <= sel_id+1` (wrapping to 0 past `NUM_REQ-1`), go to IDLE.
- Results hold their values until the next CONV capture.
- Requester rule: a requester deasserts `req` on the edge that ends its ack cycle. It may re-request after that.
- A request dropped mid-conversion does not abort the conversion. The ack is still pulsed and the requester ignores it.
- Values above 99: the converter outputs 0/0 and `result_ovf=1`, unless the clamp is enabled (see Configuration).
- `hundreds` from the converter is unused; display clients treat the result as two digits.

## Timing
- Reset values: state IDLE; `rr_ptr=0`; `grant`, `ack`, `busy`, `result_id`, `result_tens`, `result_ones`, `result_ovf`, `conv_number` all 0.
- Latency: if `req` is sampled high at edge N, then:
  - `grant` is high from cycle N+1;
  - `ack` and the results are valid in cycle N+2.
- Throughput: one conversion per 3 cycles under continuous contention.
- The converter sees a stable operand for one full cycle (CONV) before capture. The converter path must meet single-cycle timing.
- Simultaneous requests: the winner is the first set bit at or after `rr_ptr`. Any requester waits at most `NUM_REQ-1` services.
- A request arriving while `busy=1` is not sampled until the next IDLE.
- Reset in any state: the next cycle is IDLE with all outputs at their reset values. No ack is issued for the in-flight conversion.
- `grant` and `ack` are never high for more than one client.

## Configuration
- Macro: `BCD_ARB_CLAMP_EN`.
- Defined: in IDLE, values above 99 load `conv_number=99`, so the result is 9/9, and `result_ovf=1`.
- Undefined: the value passes through unchanged, the result is 0/0 (converter default), and `result_ovf=1`.

## Test plan
- Reset, then `req=0001`, value 65 -> `grant=0001` at N+1; `ack=0001`, tens 6, ones 5, `result_id=0`, ovf 0 at N+2; IDLE at N+3.
- All four clients request together (values 10, 21, 32, 43) and re-request after each ack -> service order 0, 1, 2, 3, 0, ...; 3 cycles per result; digits 1/0, 2/1, 3/2, 4/3.
- Client 2 requests with value 150:
  - clamp undefined -> 0/0, ovf 1;
  - with `BCD_ARB_CLAMP_EN` -> 9/9, ovf 1.
- Client 1 drops `req` during CONV (value 7) -> `ack=0010` is still pulsed with ones 7, then the block returns to IDLE.
- Reset asserted in CONV while serving client 3 -> no ack; all outputs 0 the next cycle; then a request from client 3 is served with `rr_ptr` starting at 0.
- Boundary values 0, 9, 10, 99 on client 0 -> 0/0, 0/9, 1/0, 9/9, all with ovf 0.

Source files
------------

// File: rtl/bcd_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// bcd_share_arbiter_if : request/result bus between display clients, the
//                        shared BCD converter and the bcd_share_arbiter.
// Revision: 1.0
// ============================================================================
interface bcd_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] number_flat;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [ID_W-1:0]      result_id;
  logic [3:0]           result_tens;
  logic [3:0]           result_ones;
  logic                 result_ovf;
  logic [7:0]           conv_number;
  logic [3:0]           conv_tens;
  logic [3:0]           conv_ones;

  // Client and converter side of the bus.
  modport master (
    output req, number_flat, conv_tens, conv_ones,
    input  grant, ack, busy, result_id, result_tens, result_ones, result_ovf,
           conv_number
  );

  modport slave (
    input  req, number_flat, conv_tens, conv_ones,
    output grant, ack, busy, result_id, result_tens, result_ones, result_ovf,
           conv_number
  );
endinterface
`default_nettype wire

// File: rtl/bcd_share_arbiter.sv
`default_nettype none
// ============================================================================
// bcd_share_arbiter : round-robin sharing of one combinational BCD converter
//                     among NUM_REQ clients. Optional macro: BCD_ARB_CLAMP_EN.
// Revision: 1.0
// ============================================================================
module bcd_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                clock,
  input  logic                reset,
  bcd_share_arbiter_if.slave  bus
);

  localparam logic [1:0]      S_IDLE  = 2'd0;
  localparam logic [1:0]      S_CONV  = 2'd1;
  localparam logic [1:0]      S_ACK   = 2'd2;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_q,       state_d;
  logic [ID_W-1:0]    rr_ptr_q,      rr_ptr_d;
  logic [ID_W-1:0]    sel_id_q,      sel_id_d;
  logic [NUM_REQ-1:0] grant_q,       grant_d;
  logic [7:0]         conv_number_q, conv_number_d;
  logic               ovf_q,         ovf_d;
  logic [ID_W-1:0]    result_id_q,   result_id_d;
  logic [3:0]         result_tens_q, result_tens_d;
  logic [3:0]         result_ones_q, result_ones_d;
  logic               result_ovf_q,  result_ovf_d;

  logic [7:0]         values [NUM_REQ];
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    scan_id;
  int                 scan_idx;
  logic [7:0]         win_value;
  logic               win_over;
  logic [7:0]         win_load;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign values[g] = bus.number_flat[8*g +: 8];
  end

  // First requester at or after rr_ptr, wrapping past the last index.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_id = ID_W'(scan_idx);
      if (!win_found && bus.req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  assign win_value = values[win_id];
  assign win_over  = (win_value > 8'd99);

`ifdef BCD_ARB_CLAMP_EN
  assign win_load = win_over ? 8'd99 : win_value;
`else
  assign win_load = win_value;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    sel_id_d      = sel_id_q;
    grant_d       = grant_q;
    conv_number_d = conv_number_q;
    ovf_d         = ovf_q;
    result_id_d   = result_id_q;
    result_tens_d = result_tens_q;
    result_ones_d = result_ones_q;
    result_ovf_d  = result_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_CONV;
          sel_id_d      = win_id;
          grant_d       = NUM_REQ'(1) << win_id;
          conv_number_d = win_load;
          ovf_d         = win_over;
        end
      end
      S_CONV: begin
        state_d       = S_ACK;
        result_id_d   = sel_id_q;
        result_tens_d = bus.conv_tens;
        result_ones_d = bus.conv_ones;
        result_ovf_d  = ovf_q;
      end
      S_ACK: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        rr_ptr_d = (sel_id_q == LAST_ID) ? '0 : sel_id_q + ID_W'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      sel_id_q      <= '0;
      grant_q       <= '0;
      conv_number_q <= '0;
      ovf_q         <= 1'b0;
      result_id_q   <= '0;
      result_tens_q <= '0;
      result_ones_q <= '0;
      result_ovf_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_id_q      <= sel_id_d;
      grant_q       <= grant_d;
      conv_number_q <= conv_number_d;
      ovf_q         <= ovf_d;
      result_id_q   <= result_id_d;
      result_tens_q <= result_tens_d;
      result_ones_q <= result_ones_d;
      result_ovf_q  <= result_ovf_d;
    end
  end

  // grant_q is one-hot on the served client, so it doubles as the ack pattern.
  assign bus.ack         = (state_q == S_ACK) ? grant_q : '0;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result_id   = result_id_q;
  assign bus.result_tens = result_tens_q;
  assign bus.result_ones = result_ones_q;
  assign bus.result_ovf  = result_ovf_q;
  assign bus.conv_number = conv_number_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bcd_share_arbiter : directed and randomized checks of bcd_share_arbiter
//                        against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_bcd_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_share_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  bcd_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared converter: two digits, 0/0 above 99.
  always_comb begin
    bus.conv_tens = 4'd0;
    bus.conv_ones = 4'd0;
    if (bus.conv_number <= 8'd99) begin
      bus.conv_tens = 4'(bus.conv_number / 8'd10);
      bus.conv_ones = 4'(bus.conv_number % 8'd10);
    end
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_req;
  logic [7:0] m_val [4];
  int         m_ptr;
  logic [3:0] last_tens, last_ones;
  logic       last_ovf;
  logic [1:0] last_id;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic apply();
    bus.req         = m_req;
    bus.number_flat = {m_val[3], m_val[2], m_val[1], m_val[0]};
  endtask

  function automatic int pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_load(input logic [7:0] v);
`ifdef BCD_ARB_CLAMP_EN
    return (v > 8'd99) ? 8'd99 : v;
`else
    return v;
`endif
  endfunction

  task automatic exp_digits(input logic [7:0] v, output logic [3:0] t, output logic [3:0] o,
                            output logic ovf);
    if (v <= 8'd99) begin
      t = 4'(v / 10); o = 4'(v % 10); ovf = 1'b0;
    end else begin
`ifdef BCD_ARB_CLAMP_EN
      t = 4'd9; o = 4'd9;
`else
      t = 4'd0; o = 4'd0;
`endif
      ovf = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(bus.busy),  32'd0);
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check_eq({tag, "_ack"},   32'(bus.ack),   32'd0);
    check_eq({tag, "_tens"},  32'(bus.result_tens), 32'(last_tens));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_idle_outputs("idle");
  endtask

  // Called at a negedge with the DUT idle and m_req non-zero.
  task automatic do_round(input bit drop_mid, input bit rst_mid, output int w);
    logic [3:0] et, eo;
    logic       eovf;
    w = pick(m_req, m_ptr);
    exp_digits(m_val[w], et, eo, eovf);
    @(negedge clk);
    check_eq("grant",     32'(bus.grant), 32'(4'b1 << w));
    check_eq("busy_conv", 32'(bus.busy),  32'd1);
    check_eq("ack_conv",  32'(bus.ack),   32'd0);
    check_eq("conv_num",  32'(bus.conv_number), 32'(exp_load(m_val[w])));
    check_eq("hold_ones", 32'(bus.result_ones), 32'(last_ones));
    if (rst_mid) begin
      rst   = 1'b1;
      m_req = 4'b0;
      apply();
      @(negedge clk);
      check_eq("rst_grant", 32'(bus.grant), 32'd0);
      check_eq("rst_ack",   32'(bus.ack),   32'd0);
      check_eq("rst_busy",  32'(bus.busy),  32'd0);
      check_eq("rst_id",    32'(bus.result_id),   32'd0);
      check_eq("rst_tens",  32'(bus.result_tens), 32'd0);
      check_eq("rst_ones",  32'(bus.result_ones), 32'd0);
      check_eq("rst_ovf",   32'(bus.result_ovf),  32'd0);
      check_eq("rst_conv",  32'(bus.conv_number), 32'd0);
      rst = 1'b0;
      m_ptr = 0;
      last_tens = 4'd0; last_ones = 4'd0; last_ovf = 1'b0; last_id = 2'd0;
      return;
    end
    if (drop_mid) begin
      m_req[w] = 1'b0;
      apply();
    end
    @(negedge clk);
    check_eq("ack",       32'(bus.ack),   32'(4'b1 << w));
    check_eq("grant_ack", 32'(bus.grant), 32'(4'b1 << w));
    check_eq("busy_ack",  32'(bus.busy),  32'd1);
    check_eq("res_id",    32'(bus.result_id),   32'(w));
    check_eq("res_tens",  32'(bus.result_tens), 32'(et));
    check_eq("res_ones",  32'(bus.result_ones), 32'(eo));
    check_eq("res_ovf",   32'(bus.result_ovf),  32'(eovf));
    m_req[w] = 1'b0;
    apply();
    last_tens = et; last_ones = eo; last_ovf = eovf; last_id = 2'(w);
    m_ptr = (w + 1) % 4;
    @(negedge clk);
    check_idle_outputs("post_ack");
    check_eq("hold_ovf", 32'(bus.result_ovf), 32'(last_ovf));
  endtask

  initial begin
    int w;
    logic [7:0] bnd [4];
    m_req = 4'b0;
    for (int c = 0; c < 4; c++) m_val[c] = 8'd0;
    m_ptr = 0;
    last_tens = 4'd0; last_ones = 4'd0; last_ovf = 1'b0; last_id = 2'd0;
    apply();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_busy",  32'(bus.busy),  32'd0);
    check_eq("reset_grant", 32'(bus.grant), 32'd0);
    check_eq("reset_ack",   32'(bus.ack),   32'd0);
    check_eq("reset_id",    32'(bus.result_id),   32'd0);
    check_eq("reset_ovf",   32'(bus.result_ovf),  32'd0);
    check_eq("reset_conv",  32'(bus.conv_number), 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Single client, value 65.
    m_val[0] = 8'd65; m_req = 4'b0001; apply();
    do_round(1'b0, 1'b0, w);

    // Full contention with immediate re-requests.
    m_val[0] = 8'd10; m_val[1] = 8'd21; m_val[2] = 8'd32; m_val[3] = 8'd43;
    m_req = 4'b1111; apply();
    for (int r = 0; r < 8; r++) begin
      do_round(1'b0, 1'b0, w);
      m_req[w] = 1'b1;
      apply();
    end
    m_req = 4'b0; apply();
    idle_cycle();

    // Over-range value.
    m_val[2] = 8'd150; m_req = 4'b0100; apply();
    do_round(1'b0, 1'b0, w);

    // Request dropped mid-conversion.
    m_val[1] = 8'd7; m_req = 4'b0010; apply();
    do_round(1'b1, 1'b0, w);
    idle_cycle();

    // Reset while converting for client 3, then re-serve it.
    m_val[3] = 8'd42; m_req = 4'b1000; apply();
    do_round(1'b0, 1'b1, w);
    m_req = 4'b1000; apply();
    do_round(1'b0, 1'b0, w);

    // Boundary values on client 0.
    bnd[0] = 8'd0; bnd[1] = 8'd9; bnd[2] = 8'd10; bnd[3] = 8'd99;
    for (int b = 0; b < 4; b++) begin
      m_val[0] = bnd[b]; m_req = 4'b0001; apply();
      do_round(1'b0, 1'b0, w);
    end

    // Randomized traffic.
    for (int r = 0; r < 80; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!m_req[c] && ($urandom_range(0, 1) == 1)) begin
          m_req[c] = 1'b1;
          m_val[c] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255))
                                                 : 8'($urandom_range(0, 99));
        end
      end
      apply();
      if (m_req == 4'b0) idle_cycle();
      else do_round($urandom_range(0, 7) == 0, 1'b0, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
